mem_access_unit: RTL and testbench

Bus master between the pipeline memory stage and the Avalon-style data bus (avalon_bus). It captures one load/store from the pipeline and drives ReadData/WriteData/DataAddr/BusIn from registers. It holds the request while Waitreq is high and returns load data after the bus read latency. It stalls the pipeline for the whole transaction.

---
 rtl/bus_pkg.sv | 14 +
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the pipeline memory stage and the Avalon-style data bus.
package bus_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int DEV_MSB = 15;
  localparam int DEV_LSB = 12;

  localparam logic [3:0] DEV_MEM = 4'h0;
  localparam logic [3:0] DEV_FP  = 4'h1;

  localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT} state_e;
endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding bus master between the pipeline memory stage and the data bus.
// Optional Waitreq watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import bus_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int NUM_DEVICES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [2:0]        DestReg,
  output logic              Stall,
  output logic              LoadValid,
  output logic [DATA_W-1:0] LoadData,
  output logic [2:0]        LoadDest,
  output logic              BusErr,
  output logic              ReadData,
  output logic              WriteData,
  output logic [ADDR_W-1:0] DataAddr,
  output logic [DATA_W-1:0] BusIn,
  input  logic [DATA_W-1:0] BusOut,
  input  logic              Waitreq
);
  localparam int          CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [4:0]  DEV_LIM = 5'(NUM_DEVICES);

  state_e              state_q, state_d;
  logic                is_rd_q, is_rd_d, unmapped_q, unmapped_d;
  logic                rd_q, rd_d, wr_q, wr_d, stall_q, stall_d, lv_q, lv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   bin_q, bin_d, ld_q, ld_d;
  logic [2:0]          dest_q, dest_d, ldest_q, ldest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef MEM_TIMEOUT_EN
  localparam int       WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                berr_q, berr_d;
`endif

  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    unmapped_d = unmapped_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    stall_d    = stall_q;
    lv_d       = 1'b0;
    addr_d     = addr_q;
    bin_d      = bin_q;
    ld_d       = ld_q;
    dest_d     = dest_q;
    ldest_d    = ldest_q;
    cnt_d      = cnt_q;
`ifdef MEM_TIMEOUT_EN
    wd_d       = wd_q;
    berr_d     = berr_q;
`endif
    unique case (state_q)
      IDLE: if (MemRead || MemWrite) begin
        // Read wins a simultaneous read/write; unmapped targets never see a strobe.
        state_d    = REQ;
        is_rd_d    = MemRead;
        unmapped_d = !({1'b0, Addr[DEV_MSB:DEV_LSB]} < DEV_LIM);
        rd_d       = MemRead && !unmapped_d;
        wr_d       = !MemRead && !unmapped_d;
        stall_d    = 1'b1;
        addr_d     = Addr;
        bin_d      = MemRead ? '0 : StoreData;
        dest_d     = DestReg;
`ifdef MEM_TIMEOUT_EN
        wd_d       = '0;
`endif
      end
      REQ: begin
        if (unmapped_q || !Waitreq) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (is_rd_q) begin
            state_d = RDWAIT;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
          end else begin
            state_d = IDLE;
            stall_d = 1'b0;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          berr_d  = 1'b1;
          state_d = IDLE;
          stall_d = 1'b0;
          if (is_rd_q) begin
            lv_d    = 1'b1;
            ld_d    = ERR_DATA;
            ldest_d = dest_q;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      RDWAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          lv_d    = 1'b1;
          ld_d    = unmapped_q ? '0 : BusOut;
          ldest_d = dest_q;
          state_d = IDLE;
          stall_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      is_rd_q    <= 1'b0;
      unmapped_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      stall_q    <= 1'b0;
      lv_q       <= 1'b0;
      addr_q     <= '0;
      bin_q      <= '0;
      ld_q       <= '0;
      dest_q     <= '0;
      ldest_q    <= '0;
      cnt_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      wd_q       <= '0;
      berr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      unmapped_q <= unmapped_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      stall_q    <= stall_d;
      lv_q       <= lv_d;
      addr_q     <= addr_d;
      bin_q      <= bin_d;
      ld_q       <= ld_d;
      dest_q     <= dest_d;
      ldest_q    <= ldest_d;
      cnt_q      <= cnt_d;
`ifdef MEM_TIMEOUT_EN
      wd_q       <= wd_d;
      berr_q     <= berr_d;
`endif
    end
  end

  assign Stall     = stall_q;
  assign LoadValid = lv_q;
  assign LoadData  = ld_q;
  assign LoadDest  = ldest_q;
  assign ReadData  = rd_q;
  assign WriteData = wr_q;
  assign DataAddr  = addr_q;
  assign BusIn     = bin_q;
`ifdef MEM_TIMEOUT_EN
  assign BusErr    = berr_q;
`else
  assign BusErr    = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a transaction-level timeline model plus a bus responder with its own memory.
module tb_mem_access_unit;
  localparam int RL  = 1;
  localparam int TMO = 64;
  localparam int N   = 1024;

  logic        Clock, Resetn, MemRead, MemWrite;
  logic [15:0] Addr, StoreData, LoadData, DataAddr, BusIn, BusOut;
  logic [2:0]  DestReg, LoadDest;
  logic        Stall, LoadValid, BusErr, ReadData, WriteData, Waitreq;

  mem_access_unit #(.READ_LATENCY(RL), .NUM_DEVICES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Resetn(Resetn), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .StoreData(StoreData), .DestReg(DestReg), .Stall(Stall),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadDest(LoadDest), .BusErr(BusErr),
    .ReadData(ReadData), .WriteData(WriteData), .DataAddr(DataAddr), .BusIn(BusIn),
    .BusOut(BusOut), .Waitreq(Waitreq));

  typedef struct packed {
    bit stall, rd, wr, lv;
    bit [15:0] addr, bin, ldata;
    bit [2:0] ldest;
  } exp_t;

  exp_t ex [N];
  bit   wq [N];
  bit [15:0] exp_mem [int];
  bit [15:0] bus_mem [int];
  int   cyc = 0, nchk = 0, nerr = 0, berr_from = 1 << 30;
  int   rd_hi = 0, wr_hi = 0;
  logic [15:0] last_ld = '0;
  bit   rd_pend, wr_pend;
  logic [15:0] pend_a, pend_d;

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Bus responder: synchronous memory, one-cycle read latency.
  always @(negedge Clock) begin
    rd_pend = ReadData && !Waitreq;
    wr_pend = WriteData && !Waitreq;
    pend_a  = DataAddr;
    pend_d  = BusIn;
  end

  always @(posedge Clock) begin
    #1;
    Waitreq = (cyc < N) ? wq[cyc] : 1'b0;
    if (wr_pend) bus_mem[int'(pend_a)] = pend_d;
    BusOut = rd_pend ? (bus_mem.exists(int'(pend_a)) ? bus_mem[int'(pend_a)] : 16'h0) : 16'h5A5A;
  end

  // Compare process: every cycle outside reset against the model timeline.
  always @(negedge Clock) begin
    if (ReadData) rd_hi++;
    if (WriteData) wr_hi++;
    if (LoadValid) last_ld = LoadData;
    if (Resetn && cyc < N) begin
      chk("stall", Stall, 16'(ex[cyc].stall));
      chk("rd_strobe", ReadData, 16'(ex[cyc].rd));
      chk("wr_strobe", WriteData, 16'(ex[cyc].wr));
      chk("load_valid", LoadValid, 16'(ex[cyc].lv));
      chk("bus_err", BusErr, 16'(cyc >= berr_from));
      if (ex[cyc].rd || ex[cyc].wr) chk("data_addr", DataAddr, ex[cyc].addr);
      if (ex[cyc].wr) chk("bus_in", BusIn, ex[cyc].bin);
      if (ex[cyc].lv) begin
        chk("load_data", LoadData, ex[cyc].ldata);
        chk("load_dest", 16'(LoadDest), 16'(ex[cyc].ldest));
      end
    end
  end

  // Called #1 after a clock edge; returns #1 after the edge that starts window 'done'.
  task automatic txn(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [2:0] dst, input int w, output int c, output int done);
    bit mapped, to;
    int weff, g;
    c      = cyc + 1;
    mapped = a[15:12] < 4'd2;
    to     = 0;
    weff   = mapped ? w : 0;
`ifdef MEM_TIMEOUT_EN
    if (mapped && w >= TMO) begin to = 1; weff = TMO - 1; end
`endif
    for (int k = c; k < c + w && k < N; k++) wq[k] = 1;
    for (int k = c; k <= c + weff; k++) begin
      ex[k].stall = 1;
      ex[k].rd    = rd && mapped;
      ex[k].wr    = !rd && mapped;
      ex[k].addr  = a;
      ex[k].bin   = rd ? 16'h0 : d;
    end
    if (to) begin
      done = c + weff + 1;
      berr_from = done;
      if (rd) begin ex[done].lv = 1; ex[done].ldata = 16'hDEAD; ex[done].ldest = dst; end
    end else if (rd) begin
      for (int k = c + weff + 1; k <= c + weff + RL; k++) ex[k].stall = 1;
      done = c + weff + RL + 1;
      ex[done].lv    = 1;
      ex[done].ldata = mapped ? (exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 16'h0) : 16'h0;
      ex[done].ldest = dst;
    end else begin
      if (mapped) exp_mem[int'(a)] = d;
      done = c + weff + 1;
    end
    if (c + w > done) done = c + w;
    MemRead = rd; MemWrite = wr; Addr = a; StoreData = d; DestReg = dst;
    @(posedge Clock); #1;
    MemRead = 0; MemWrite = 0; Addr = 16'h3333; StoreData = 16'h7777; DestReg = 3'd6;
    g = 0;
    while (cyc < done && g < 2000) begin @(posedge Clock); #1; g++; end
    if (g >= 2000) begin
      nchk++; nerr++;
      $display("FAIL txn_timeout: got cycle %0d expected cycle %0d", cyc, done);
    end
  endtask

  initial begin
    int c, dn, r0, w0;
    Resetn = 0; MemRead = 0; MemWrite = 0; Addr = 0; StoreData = 0; DestReg = 0;
    Waitreq = 0; BusOut = 16'h5A5A;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_stall", Stall, 0);       chk("rst_lv", LoadValid, 0);
    chk("rst_ld", LoadData, 0);       chk("rst_ldest", 16'(LoadDest), 0);
    chk("rst_berr", BusErr, 0);       chk("rst_rd", ReadData, 0);
    chk("rst_wr", WriteData, 0);      chk("rst_addr", DataAddr, 0);
    chk("rst_busin", BusIn, 0);
    #1 Resetn = 1;
    @(posedge Clock); #1;

    txn(0, 1, 16'h0010, 16'hBEEF, 3'd0, 0, c, dn);
    chk("st_wr_cnt", 16'(wr_hi), 1);  chk("st_wr_done", WriteData, 0);
    chk("st_stall_done", Stall, 0);

    txn(1, 0, 16'h0010, 16'h0000, 3'd3, 0, c, dn);
    chk("ld_latency", 16'(dn - c), 2);  chk("ld_lv", LoadValid, 1);
    chk("ld_data", LoadData, 16'hBEEF); chk("ld_dest", 16'(LoadDest), 3);
    chk("ld_stall", Stall, 0);

    txn(0, 1, 16'h1004, 16'h1234, 3'd0, 2, c, dn);
    r0 = rd_hi;
    txn(1, 0, 16'h1004, 16'h0000, 3'd5, 5, c, dn);
    chk("fp_rd_cycles", 16'(rd_hi - r0), 6); chk("fp_data", LoadData, 16'h1234);

    txn(0, 1, 16'h0020, 16'hA5A5, 3'd0, 0, c, dn);
    w0 = wr_hi; r0 = rd_hi;
    txn(1, 1, 16'h0020, 16'hFFFF, 3'd1, 0, c, dn);
    chk("both_no_wr", 16'(wr_hi - w0), 0); chk("both_rd", 16'(rd_hi - r0), 1);
    chk("both_data", LoadData, 16'hA5A5);

    w0 = wr_hi; r0 = rd_hi;
    txn(1, 0, 16'h7000, 16'h0000, 3'd7, 3, c, dn);
    txn(0, 1, 16'h8000, 16'h4444, 3'd0, 0, c, dn);
    chk("unm_no_strobe", 16'((rd_hi - r0) + (wr_hi - w0)), 0);
    chk("unm_data", last_ld, 16'h0000);

    txn(1, 0, 16'h0010, 16'h0000, 3'd2, 1, c, dn);
    chk("b2b_data", LoadData, 16'hBEEF);

    // Reset asserted in the middle of REQ.
    c = cyc + 1;
    for (int k = c; k < c + 20; k++) wq[k] = 1;
    ex[c].stall = 1; ex[c].rd = 1; ex[c].addr = 16'h0010;
    MemRead = 1; Addr = 16'h0010; DestReg = 3'd4;
    @(posedge Clock); #1;
    MemRead = 0;
    chk("mid_pre_rd", ReadData, 1); chk("mid_pre_stall", Stall, 1);
    #2 Resetn = 0;
    #1;
    chk("mid_rd", ReadData, 0); chk("mid_stall", Stall, 0); chk("mid_addr", DataAddr, 0);
    for (int k = cyc; k < N; k++) begin ex[k] = '0; wq[k] = 0; end
    Waitreq = 0;
    repeat (2) @(posedge Clock);
    #2 Resetn = 1;
    @(posedge Clock); #1;

`ifdef MEM_TIMEOUT_EN
    fork
      txn(1, 0, 16'h0030, 16'h0000, 3'd6, 70, c, dn);
      begin repeat (66) @(posedge Clock); #1; chk("tmo_berr", BusErr, 1); end
    join
    chk("tmo_data", last_ld, 16'hDEAD);
    chk("tmo_sticky", BusErr, 1);
`else
    fork
      txn(1, 0, 16'h0010, 16'h0000, 3'd6, 200, c, dn);
      begin
        repeat (200) @(posedge Clock); #1;
        chk("hold200_stall", Stall, 1); chk("hold200_rd", ReadData, 1);
        chk("hold200_berr", BusErr, 0);
      end
    join
    chk("hold_data", LoadData, 16'hBEEF);
`endif
    repeat (2) @(posedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
